se_sram_bus_bridge: RTL
=======================

# se_sram_bus_bridge

Request/response bridge between a core-side load/store port and a single-port 16384x32 byte-write-enabled SRAM wrapper. It sits directly upstream of the SRAM. It accepts one byte, half or word request at a time over a valid/ready handshake and drives the SRAM select, direction, address, byte enables and lane-replicated write data. It returns a registered response held until acknowledged. Misaligned requests are rejected with an error response and never reach the SRAM.

## Interface
Parameters:
- address_width, 14, SRAM word-address width; byte-address bits [address_width+1:2] form the SRAM address.
- data_width, 32, data path width; only 32 is supported.

Ports:
- sram_clock  in  1  single clock for bridge and SRAM.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_address  in  32  byte address.
- req_read_not_write  in  1  1 = load, 0 = store.
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal.
- req_sign  in  1  sign-extend load result.
- req_write_data  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ack  in  1  response consumed when high with resp_valid.
- resp_read_data  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal-size request.
- sram_clock__enable  out  1  tied 1.
- sram_select  out  1  SRAM access strobe.
- sram_read_not_write  out  1  SRAM direction.
- sram_address  out  address_width  SRAM word address.
- sram_write_enable  out  4  byte-lane enables.
- sram_write_data  out  32  lane-replicated store data.
- sram_data_out  in  32  SRAM registered read data.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - RDATA: one cycle, SRAM read data arriving.
  - RESP: response held for the consumer.
- req_ready = (state==IDLE) || (state==RESP && resp_ack).
- On accept (req_valid && req_ready), request fields drive SRAM ports combinationally in the same cycle. sram_select = accept && !error && reset_n. When not selecting, all other SRAM outputs are 0.
- Error conditions:
  - size 3;
  - half with address[0]=1;
  - word with address[1:0]!=0.
- An error request makes no SRAM access and goes to RESP with resp_error=1 and resp_read_data=0.
- Store byte enables:
  - byte: 4'b0001<<address[1:0], write data {4{wd[7:0]}};
  - half: 4'b0011<<address[1:0], write data {2{wd[15:0]}};
  - word: 4'hf, write data wd.
- A store goes IDLE→RESP with resp_read_data=0.
- A load goes IDLE→RDATA. In RDATA, sram_data_out is captured (formatted per Configuration) into the response register, then RESP.
- Lane offset, size and sign are latched at accept.
- In RESP, an ack with no new request returns to IDLE. An ack together with req_valid accepts the new request in the same cycle (back-to-back).
- Upper address bits above address_width+1 are ignored; no range error is raised.

## Timing
- Reset values: resp_valid 0, resp_error 0, resp_read_data 0, state IDLE, req_ready 1 after reset release, all SRAM outputs 0.
- Store or error: accept in cycle N; resp_valid in cycle N+1.
- Load: accept in cycle N (SRAM samples at end of N); RDATA in N+1; resp_valid in N+2.
- Sustained throughput with resp_ack held high:
  - stores: one per cycle;
  - loads: one per two cycles.
- Response fields are stable while resp_valid && !resp_ack.
- Asserting reset_n low at any point, including RDATA or RESP, immediately forces IDLE and clears the response. sram_select drops combinationally, so no write commits on a reset edge. A pending load result is discarded.
- resp_ack while resp_valid=0 is ignored.

## Configuration
- SE_SRAM_BUS_BRIDGE_READ_ALIGN_EN defined: the load word is shifted right by 8*offset, masked to size, then sign-extended if req_sign else zero-extended.
- SE_SRAM_BUS_BRIDGE_READ_ALIGN_EN undefined: resp_read_data is the raw 32-bit SRAM word for every load size; req_sign is ignored.
- Byte-enable and write-lane generation are identical in both builds.

## Test plan
- Word store 0xDEADBEEF at 0x0000_0010, then word load at 0x10 -> sram_address=4, write_enable=4'hf; store resp_valid at N+1; load returns 0xDEADBEEF at N+2, resp_error=0.
- Byte store 0x80 at 0x13, then byte load at 0x13 with req_sign=1 -> write_enable=4'b1000, write_data=0x80808080. With the macro, load returns 0xFFFFFF80; without it, returns the raw word with 0x80 in bits [31:24].
- Half load at 0x1 and word load at 0x2 -> no sram_select; each gives resp_error=1 and resp_read_data=0 one cycle after accept.
- Hold resp_ack=0 for 5 cycles after a load response -> req_ready=0 and response stable throughout. Raise resp_ack together with a new store -> store accepted in that same cycle.
- Four back-to-back stores with resp_ack=1 -> four accepts in four consecutive cycles, sram_select high each cycle.
- Assert reset_n low during RDATA -> resp_valid never asserts, and after reset release the state is IDLE with req_ready=1.

Source files
------------

// File: rtl/se_sram_bus_bridge.sv
// Load/store request bridge in front of a single-port byte-write SRAM; rejects misaligned requests.
// Optional macro SE_SRAM_BUS_BRIDGE_READ_ALIGN_EN enables lane alignment and sign extension of load data.
module se_sram_bus_bridge #(
  parameter int unsigned address_width = 14,
  parameter int unsigned data_width    = 32
) (
  input  logic                     sram_clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_address,
  input  logic                     req_read_not_write,
  input  logic [1:0]               req_size,
  input  logic                     req_sign,
  input  logic [data_width-1:0]    req_write_data,
  output logic                     resp_valid,
  input  logic                     resp_ack,
  output logic [data_width-1:0]    resp_read_data,
  output logic                     resp_error,
  output logic                     sram_clock__enable,
  output logic                     sram_select,
  output logic                     sram_read_not_write,
  output logic [address_width-1:0] sram_address,
  output logic [3:0]               sram_write_enable,
  output logic [data_width-1:0]    sram_write_data,
  input  logic [data_width-1:0]    sram_data_out
);

  localparam int unsigned AW = address_width;

  typedef enum logic [1:0] {IDLE, RDATA, RESP} state_t;

  state_t                state_q, state_d;
  logic [data_width-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  accept, req_err;
  logic [1:0]            req_off;

  // Upper byte-address bits are outside the SRAM and deliberately dropped.
  logic unused_inputs;
  assign unused_inputs = ^{req_address[31:AW+2], req_sign};

`ifdef SE_SRAM_BUS_BRIDGE_READ_ALIGN_EN
  logic [1:0] off_q, off_d;
  logic [1:0] size_q, size_d;
  logic       sign_q, sign_d;

  function automatic logic [31:0] align_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic sgn);
    logic [31:0] sh;
    logic [31:0] res;
    sh = w >> {off, 3'b000};
    case (sz)
      2'd0:    res = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    res = {{16{sgn & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction
`endif

  assign sram_clock__enable = 1'b1;
  assign resp_valid         = (state_q == RESP);
  assign resp_read_data     = resp_data_q;
  assign resp_error         = resp_err_q;
  assign req_off            = req_address[1:0];

  // Next state, response capture and combinational SRAM drive.
  always_comb begin
    state_d             = state_q;
    resp_data_d         = resp_data_q;
    resp_err_d          = resp_err_q;
    sram_select         = 1'b0;
    sram_read_not_write = 1'b0;
    sram_address        = '0;
    sram_write_enable   = 4'b0000;
    sram_write_data     = '0;
`ifdef SE_SRAM_BUS_BRIDGE_READ_ALIGN_EN
    off_d  = off_q;
    size_d = size_q;
    sign_d = sign_q;
`endif

    req_ready = (state_q == IDLE) || ((state_q == RESP) && resp_ack);
    accept    = req_valid && req_ready;
    req_err   = (req_size == 2'd3) ||
                ((req_size == 2'd1) && req_off[0]) ||
                ((req_size == 2'd2) && (req_off != 2'd0));

    if (accept && !req_err && reset_n) begin
      sram_select         = 1'b1;
      sram_read_not_write = req_read_not_write;
      sram_address        = req_address[AW+1:2];
      if (!req_read_not_write) begin
        case (req_size)
          2'd0: begin
            sram_write_enable = 4'(4'b0001 << req_off);
            sram_write_data   = {4{req_write_data[7:0]}};
          end
          2'd1: begin
            sram_write_enable = 4'(4'b0011 << req_off);
            sram_write_data   = {2{req_write_data[15:0]}};
          end
          default: begin
            sram_write_enable = 4'hf;
            sram_write_data   = req_write_data;
          end
        endcase
      end
    end

    case (state_q)
      RDATA: begin
`ifdef SE_SRAM_BUS_BRIDGE_READ_ALIGN_EN
        resp_data_d = align_load(sram_data_out, off_q, size_q, sign_q);
`else
        resp_data_d = sram_data_out;
`endif
        resp_err_d  = 1'b0;
        state_d     = RESP;
      end
      default: begin
        if (accept) begin
          resp_data_d = '0;
          resp_err_d  = req_err;
          state_d     = (!req_err && req_read_not_write) ? RDATA : RESP;
`ifdef SE_SRAM_BUS_BRIDGE_READ_ALIGN_EN
          off_d  = req_off;
          size_d = req_size;
          sign_d = req_sign;
`endif
        end else if (state_q == RESP && resp_ack) begin
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

`ifdef SE_SRAM_BUS_BRIDGE_READ_ALIGN_EN
  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      off_q  <= 2'd0;
      size_q <= 2'd0;
      sign_q <= 1'b0;
    end else begin
      off_q  <= off_d;
      size_q <= size_d;
      sign_q <= sign_d;
    end
  end
`endif

endmodule
